debounce_sync: RTL and testbench
================================

DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive clk samples of a new synchronized level required before the clean output changes; legal range 1..2^CNT_W-1.
REQ-002 Parameter CNT_W, default 8: width of the internal stability counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 clear  input  1  asynchronous, active-high reset.
REQ-005 d_raw  input  1  asynchronous, bouncing level, e.g. a push-button or switch.
REQ-006 d  output  1  clean, synchronized, debounced level; drives the d input of the downstream flip-flop stage.
REQ-007 rise  output  1  one-cycle pulse when d goes 0->1.
REQ-008 fall  output  1  one-cycle pulse when d goes 1->0.
REQ-009 busy  output  1  high while a candidate level change is being qualified.

Function
REQ-010 d_raw SHALL pass through a 2-flop synchronizer; d_sync is the second flop, valid one edge after the first flop captures.
REQ-011 The FSM SHALL have states S_LOW, S_TO_HIGH, S_HIGH, S_TO_LOW; d = 1 exactly in S_HIGH and S_TO_LOW.
REQ-012 S_LOW, d_sync=1: if STABLE_CYCLES=1, go to S_HIGH; else go to S_TO_HIGH with cnt=1.
REQ-013 S_TO_HIGH, d_sync=0: abort to S_LOW, cnt=0, no pulse.
REQ-014 S_TO_HIGH, d_sync=1: if cnt=STABLE_CYCLES-1, go to S_HIGH and clear cnt; else increment cnt.
REQ-015 S_HIGH, S_TO_LOW: mirror REQ-012..014 with levels inverted.
REQ-016 Latency: d_raw stable and setup-met before edge k SHALL change d after edge k+1+STABLE_CYCLES; this is edge k+5 at the default.
REQ-017 rise and fall SHALL be registered, asserted for exactly the one cycle following the edge at which d changes, and never both high.
REQ-018 busy = 1 exactly in S_TO_HIGH and S_TO_LOW.
REQ-019 A glitch shorter than STABLE_CYCLES synchronized samples SHALL NOT change d or pulse rise/fall.
REQ-020 The counter SHALL never exceed STABLE_CYCLES-1; no wrap-around is permitted.

Reset
REQ-021 clear=1 SHALL immediately force, with no clk edge needed: both sync flops 0, state S_LOW, cnt 0, d 0, rise 0, fall 0, busy 0.
REQ-022 clear asserted mid-qualification SHALL discard progress; after release, qualification restarts from S_LOW.
REQ-023 After clear deasserts with d_raw=1, d SHALL rise per REQ-016, counting from the first edge after release, and rise SHALL pulse.

Configuration
REQ-024 Macro DEBOUNCE_EDGE_EN defined: rise/fall behave per REQ-017.
REQ-025 Macro DEBOUNCE_EDGE_EN undefined: rise/fall SHALL be tied to 0, the pulse registers SHALL be absent, and ports plus all other behaviour SHALL be unchanged.

Verification
(clk period 10, STABLE_CYCLES=4, DEBOUNCE_EDGE_EN defined, unless stated otherwise)
REQ-026 clear=1 for 20, d_raw toggling -> d, rise, fall, busy all 0 throughout.
REQ-027 Clean step: d_raw 0->1 held 100 -> d=1 exactly 5 edges after capture, rise high one cycle, busy high 3 cycles before.
REQ-028 Bounce: d_raw 1 for 20, 0 for 10, 1 for 20, then held -> no rise during bounce; d=1 only after 4 consecutive high samples; a single rise pulse.
REQ-029 Release: d=1, then d_raw->0 held -> d=0 at latency 5, fall pulses once, rise stays 0.
REQ-030 clear pulsed high for 10 while in S_TO_HIGH (cnt=2) -> d stays 0, cnt resets, requalification takes full latency after release.
REQ-031 DEBOUNCE_EDGE_EN undefined, repeat REQ-027 -> d identical, rise and fall constantly 0.

Source files
------------

// File: rtl/debounce_sync.sv
// Debouncer for an asynchronous, bouncing level: 2-flop synchronizer, 4-state qualifier FSM, optional edge pulses.
// Build option: define DEBOUNCE_EDGE_EN to get registered rise/fall pulses; otherwise both outputs are tied low.
module debounce_sync #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic clear,
    input  logic d_raw,
    output logic d,
    output logic rise,
    output logic fall,
    output logic busy
);

    // Encoding chosen so that d is state[1] and busy is state[0].
    localparam logic [1:0] S_LOW     = 2'b00;
    localparam logic [1:0] S_TO_HIGH = 2'b01;
    localparam logic [1:0] S_HIGH    = 2'b10;
    localparam logic [1:0] S_TO_LOW  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1;
    logic             d_sync;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: sequential state uses non-blocking assignments so both flops sample the pre-edge values.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            sync1  <= 1'b0;
            d_sync <= 1'b0;
        end else begin
            sync1  <= d_raw;
            d_sync <= sync1;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_LOW: begin
                if (d_sync) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = S_HIGH;
                    end else begin
                        state_d = S_TO_HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            S_TO_HIGH: begin
                if (!d_sync) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!d_sync) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = S_LOW;
                    end else begin
                        state_d = S_TO_LOW;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            S_TO_LOW: begin
                if (d_sync) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign d    = state_q[1];
    assign busy = state_q[0];

`ifdef DEBOUNCE_EDGE_EN
    // Pulses fire on the same edge that changes d; an aborted qualification never touches state[1].
    logic rise_d;
    logic fall_d;

    assign rise_d = state_d[1] & ~state_q[1];
    assign fall_d = ~state_d[1] & state_q[1];

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= rise_d;
            fall <= fall_d;
        end
    end
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!clear) begin
            assert (!(rise && fall));
            assert (cnt_q <= CNT_LAST);
        end
    end
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync at STABLE_CYCLES=4; expected edge pulses follow DEBOUNCE_EDGE_EN.
module tb_debounce_sync;

`ifdef DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic clk;
    logic clear;
    logic d_raw;
    logic d;
    logic rise;
    logic fall;
    logic busy;

    int n_cmp = 0;
    int n_err = 0;

    debounce_sync #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
        .clk   (clk),
        .clear (clear),
        .d_raw (d_raw),
        .d     (d),
        .rise  (rise),
        .fall  (fall),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ed, input logic er,
                             input logic ef, input logic eb);
        check({tag, ".d"},    d,    ed);
        check({tag, ".rise"}, rise, er & EDGE_EN);
        check({tag, ".fall"}, fall, ef & EDGE_EN);
        check({tag, ".busy"}, busy, eb);
    endtask

    // One rising edge, then sample 1 time unit later.
    task automatic step(input string tag, input logic ed, input logic er,
                        input logic ef, input logic eb);
        @(posedge clk);
        #1;
        check_all(tag, ed, er, ef, eb);
    endtask

    // d_raw already 1 before edge k: two sync edges, three busy cycles, d and rise after k+5.
    task automatic rise_seq(input string tag);
        step({tag, "_k0"}, 1'b0, 1'b0, 1'b0, 1'b0);
        step({tag, "_k1"}, 1'b0, 1'b0, 1'b0, 1'b0);
        step({tag, "_k2"}, 1'b0, 1'b0, 1'b0, 1'b1);
        step({tag, "_k3"}, 1'b0, 1'b0, 1'b0, 1'b1);
        step({tag, "_k4"}, 1'b0, 1'b0, 1'b0, 1'b1);
        step({tag, "_k5"}, 1'b1, 1'b1, 1'b0, 1'b0);
        step({tag, "_k6"}, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic fall_seq(input string tag);
        step({tag, "_m0"}, 1'b1, 1'b0, 1'b0, 1'b0);
        step({tag, "_m1"}, 1'b1, 1'b0, 1'b0, 1'b0);
        step({tag, "_m2"}, 1'b1, 1'b0, 1'b0, 1'b1);
        step({tag, "_m3"}, 1'b1, 1'b0, 1'b0, 1'b1);
        step({tag, "_m4"}, 1'b1, 1'b0, 1'b0, 1'b1);
        step({tag, "_m5"}, 1'b0, 1'b0, 1'b1, 1'b0);
        step({tag, "_m6"}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear = 1'b1;
        d_raw = 1'b0;
        #1;
        check_all("rst_t1", 1'b0, 1'b0, 1'b0, 1'b0);

        // Held in reset while the input toggles.
        for (int i = 0; i < 4; i++) begin
            d_raw = ~d_raw;
            step($sformatf("rst_tog%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Release with d_raw already high: full latency from the first edge after release.
        clear = 1'b0;
        d_raw = 1'b1;
        rise_seq("step_up");
        for (int i = 0; i < 3; i++)
            step($sformatf("hold_hi%0d", i), 1'b1, 1'b0, 1'b0, 1'b0);

        d_raw = 1'b0;
        fall_seq("release");
        step("hold_lo", 1'b0, 1'b0, 1'b0, 1'b0);

        // Bounce: high for two samples, one low sample, then held high.
        d_raw = 1'b1;
        step("bnc_j0", 1'b0, 1'b0, 1'b0, 1'b0);
        step("bnc_j1", 1'b0, 1'b0, 1'b0, 1'b0);
        d_raw = 1'b0;
        step("bnc_j2", 1'b0, 1'b0, 1'b0, 1'b1);
        d_raw = 1'b1;
        step("bnc_j3", 1'b0, 1'b0, 1'b0, 1'b1);
        step("bnc_j4", 1'b0, 1'b0, 1'b0, 1'b0);
        step("bnc_j5", 1'b0, 1'b0, 1'b0, 1'b1);
        step("bnc_j6", 1'b0, 1'b0, 1'b0, 1'b1);
        step("bnc_j7", 1'b0, 1'b0, 1'b0, 1'b1);
        step("bnc_j8", 1'b1, 1'b1, 1'b0, 1'b0);
        step("bnc_j9", 1'b1, 1'b0, 1'b0, 1'b0);

        d_raw = 1'b0;
        fall_seq("back_lo");

        // Clear pulse while qualifying (cnt=2): progress discarded, full restart.
        d_raw = 1'b1;
        step("cq_k0", 1'b0, 1'b0, 1'b0, 1'b0);
        step("cq_k1", 1'b0, 1'b0, 1'b0, 1'b0);
        step("cq_k2", 1'b0, 1'b0, 1'b0, 1'b1);
        step("cq_k3", 1'b0, 1'b0, 1'b0, 1'b1);
        clear = 1'b1;
        #2;
        check_all("cq_async", 1'b0, 1'b0, 1'b0, 1'b0);
        step("cq_held", 1'b0, 1'b0, 1'b0, 1'b0);
        clear = 1'b0;
        rise_seq("requal");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
